// File: rtl/key_sched_ctrl.sv
// Round-key sequencer: captures a master key, then streams NUM_ROUNDS+1 round keys
// while driving an external combinational key-update datapath with key and round.
module key_sched_ctrl #(
  parameter int KEY_W      = 80,
  parameter int ROUND_W    = 5,
  parameter int NUM_ROUNDS = 31
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_valid,
  output logic               key_ready,
  input  logic [KEY_W-1:0]   key_in,
  input  logic               abort,
  output logic               rk_valid,
  input  logic               rk_ready,
  output logic [KEY_W-1:0]   rk_out,
  output logic [ROUND_W-1:0] rk_round,
  output logic               rk_last,
  output logic [KEY_W-1:0]   ksa_key,
  output logic [ROUND_W-1:0] ksa_round,
  input  logic [KEY_W-1:0]   ksa_next,
  output logic               busy
);

  generate
    if ((2 ** ROUND_W) <= NUM_ROUNDS) begin : g_round_w_check
      $error("key_sched_ctrl: ROUND_W too narrow for NUM_ROUNDS");
    end
  endgenerate

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);

  typedef enum logic {
    IDLE = 1'b0,
    GEN  = 1'b1
  } state_t;

  state_t             state;
  logic [KEY_W-1:0]   key_reg;
  logic [ROUND_W-1:0] round_reg;

  // Abort outranks both handshakes; on the final round the key and round simply hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_reg   <= '0;
      round_reg <= '0;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (key_valid) begin
            key_reg   <= key_in;
            round_reg <= '0;
            state     <= GEN;
          end
        end
        GEN: begin
          if (rk_ready) begin
            if (round_reg == LAST_ROUND) begin
              state <= IDLE;
            end else begin
              key_reg   <= ksa_next;
              round_reg <= round_reg + ROUND_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign key_ready = (state == IDLE);
  assign busy      = (state == GEN);
  assign rk_valid  = (state == GEN);
  assign rk_last   = (state == GEN) && (round_reg == LAST_ROUND);
  assign rk_out    = key_reg;
  assign rk_round  = round_reg;
  assign ksa_key   = key_reg;
  // Wraps to zero on the last round; the datapath result is unused then.
  assign ksa_round = round_reg + ROUND_W'(1);

endmodule
